// File: rtl/rng_pkg.sv
// Shared constants, draw FSM states and the LFSR step function for the game RNG path.
package rng_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam int RAND_W = 2;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } draw_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] s,
    input logic [LFSR_W-1:0] taps = LFSR_TAPS
  );
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with seed load, stir mask and zero-state recovery.
import rng_pkg::*;

module lfsr_core #(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_seed_ld,
  input  logic [WIDTH-1:0] i_seed_in,
  input  logic [WIDTH-1:0] i_stir_mask,
  output logic             o_lsb,
  output logic             o_lockup
);

  logic [WIDTH-1:0] r_state;
  logic             r_lockup;
  logic [WIDTH-1:0] w_step;
  logic             w_zero;
  logic             w_seed_zero;

  generate
    if (WIDTH == LFSR_W) begin : g_pkg
      assign w_step = lfsr_step(r_state, TAPS);
    end else begin : g_gen
      assign w_step = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
    end
  endgenerate

  assign w_zero      = (r_state == '0);
  assign w_seed_zero = (i_seed_in == '0);

  // A zero seed would lock the register, so it falls back to SEED.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= SEED;
      r_lockup <= 1'b0;
    end else if (i_seed_ld) begin
      r_state <= w_seed_zero ? SEED : i_seed_in;
      if (w_seed_zero)
        r_lockup <= 1'b1;
    end else if (w_zero) begin
      r_state  <= SEED;
      r_lockup <= 1'b1;
    end else begin
      r_state <= w_step ^ i_stir_mask;
    end
  end

  assign o_lsb    = r_state[0];
  assign o_lockup = r_lockup;

endmodule

// File: rtl/lfsr_entropy.sv
// Entropy source: free-running LFSR plus serial draw FSM feeding the game RNG.
// Optional stir of player-input timing when IRON_VIOLET_RNG_STIR_EN is defined.
import rng_pkg::*;

module lfsr_entropy #(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED,
  parameter int               OUT_W = RAND_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SEED_LD,
  input  logic [WIDTH-1:0] SEED_IN,
  input  logic             STIR,
  input  logic             REQ,
  output logic             VALID,
  output logic [OUT_W-1:0] OUT,
  output logic             BUSY,
  output logic             LOCKUP
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  draw_state_t      r_fsm;
  draw_state_t      w_fsm_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_sr;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;
  logic [OUT_W-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_stir_mask;
  logic             w_lsb;
  logic             w_busy;
  logic             w_arm;
  logic             w_shift;
  logic             w_done;

`ifdef IRON_VIOLET_RNG_STIR_EN
  logic [3:0]       r_stir_cnt;
  logic [WIDTH-1:0] w_onehot;

  always_ff @(posedge CLK) begin
    if (RST)
      r_stir_cnt <= '0;
    else
      r_stir_cnt <= r_stir_cnt + 4'd1;
  end

  assign w_onehot    = {{(WIDTH-1){1'b0}}, 1'b1}
                       << (32'(r_stir_cnt) % WIDTH);
  assign w_stir_mask = STIR ? w_onehot : '0;
`else
  logic w_unused_stir;

  assign w_unused_stir = STIR;
  assign w_stir_mask   = '0;
`endif

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_seed_ld   (SEED_LD),
    .i_seed_in   (SEED_IN),
    .i_stir_mask (w_stir_mask),
    .o_lsb       (w_lsb),
    .o_lockup    (LOCKUP)
  );

  always_ff @(posedge CLK) begin
    if (RST)
      r_fsm <= ST_IDLE;
    else
      r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      ST_IDLE:
        if (REQ) w_fsm_nxt = ST_COLLECT;
      ST_COLLECT:
        if (SEED_LD || w_done) w_fsm_nxt = ST_IDLE;
      default:
        w_fsm_nxt = ST_IDLE;
    endcase
  end

  // A reseed mid-draw aborts it, even on the final collect edge.
  always_comb begin
    w_busy  = (r_fsm == ST_COLLECT);
    w_arm   = (r_fsm == ST_IDLE) && REQ;
    w_shift = w_busy && !SEED_LD;
    w_done  = w_shift && (r_cnt == CNT_W'(OUT_W - 1));
  end

  generate
    if (OUT_W == 1) begin : g_sr1
      assign w_sr_nxt = w_lsb;
    end else begin : g_srn
      assign w_sr_nxt = {w_lsb, r_sr[OUT_W-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_sr    <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_arm) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
        r_sr  <= w_sr_nxt;
      end
      if (w_done)
        r_out <= w_sr_nxt;
    end
  end

  assign VALID = r_valid;
  assign OUT   = r_out;
  assign BUSY  = w_busy;

endmodule

// File: tb/tb_lfsr_entropy.sv
// Directed bench for lfsr_entropy: reset, draws, abort, reseed, full period.
`timescale 1ns/1ps
import rng_pkg::*;

module tb_lfsr_entropy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_ld = 1'b0;
  logic [15:0] seed_in = '0;
  logic        stir = 1'b0;
  logic        req = 1'b0;
  logic        valid;
  logic [1:0]  out;
  logic        busy;
  logic        lockup;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_entropy u_dut (
    .CLK     (clk),
    .RST     (rst),
    .SEED_LD (seed_ld),
    .SEED_IN (seed_in),
    .STIR    (stir),
    .REQ     (req),
    .VALID   (valid),
    .OUT     (out),
    .BUSY    (busy),
    .LOCKUP  (lockup)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] st();
    return u_dut.u_core.r_state;
  endfunction

  initial begin
    logic [15:0] exp_st [3];
    logic [1:0]  exp_out [3];
    bit          early;
    bit          zero_seen;

    exp_st[0]  = 16'hE270;
    exp_st[1]  = 16'h7138;
    exp_st[2]  = 16'h389C;
    exp_out[0] = 2'b00;
    exp_out[1] = 2'b10;
    exp_out[2] = 2'b01;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", 32'(st()), 32'hACE1);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lockup", 32'(lockup), 0);

    // idle stepping; stir has no effect in the default build
`ifndef IRON_VIOLET_RNG_STIR_EN
    stir = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_state%0d", i), 32'(st()), 32'(exp_st[i]));
      chk($sformatf("idle_valid%0d", i), 32'(valid), 0);
    end
    stir = 1'b0;
    chk("idle_lockup", 32'(lockup), 0);

    // single draw
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("d1_busy_a", 32'(busy), 1);
    chk("d1_valid_a", 32'(valid), 0);
    tick();
    chk("d1_busy_b", 32'(busy), 1);
    chk("d1_valid_b", 32'(valid), 0);
    tick();
    chk("d1_valid_c", 32'(valid), 1);
    chk("d1_out", 32'(out), 0);
    chk("d1_busy_c", 32'(busy), 0);
    tick();
    chk("d1_valid_d", 32'(valid), 0);

    // back-to-back draws with REQ held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("b2b_valid%0d", i), 32'(valid),
          32'((i % 3) == 0));
      if ((i % 3) == 0)
        chk($sformatf("b2b_out%0d", i), 32'(out),
            32'(exp_out[i/3-1]));
    end
    req = 1'b0;
    chk("b2b_state_model", 32'(st()),
        32'(lfsr_step(16'hC2C4)));

    // abort on first collect edge, then a fresh draw
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("ab_busy_arm", 32'(busy), 1);
    seed_ld = 1'b1;
    seed_in = 16'h0007;
    tick();
    seed_ld = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_valid", 32'(valid), 0);
    chk("ab_out_held", 32'(out), 32'h1);
    chk("ab_state", 32'(st()), 32'h0007);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("ab2_busy", 32'(busy), 1);
    chk("ab2_state", 32'(st()), 32'hB403);
    tick();
    chk("ab2_valid_a", 32'(valid), 0);
    tick();
    chk("ab2_valid_b", 32'(valid), 1);
    chk("ab2_out", 32'(out), 32'h3);

    // zero seed -> recovery seed, sticky lockup
    seed_ld = 1'b1;
    seed_in = 16'h0000;
    tick();
    chk("z_state", 32'(st()), 32'hACE1);
    chk("z_lockup", 32'(lockup), 1);
    seed_in = 16'h0001;
    tick();
    seed_ld = 1'b0;
    chk("s1_state", 32'(st()), 32'h0001);
    chk("s1_lockup", 32'(lockup), 1);
    tick();
    chk("s1_step", 32'(st()), 32'hB400);
    tick();
    tick();
    chk("z_sticky", 32'(lockup), 1);
    rst = 1'b1;
    tick();
    chk("z_rst_clear", 32'(lockup), 0);
    chk("z_rst_state", 32'(st()), 32'hACE1);
    rst = 1'b0;

    // full period
    early = 1'b0;
    zero_seen = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (i < 65535 && st() == 16'hACE1) early = 1'b1;
      if (st() == 16'h0000) zero_seen = 1'b1;
    end
    chk("per_early", 32'(early), 0);
    chk("per_zero", 32'(zero_seen), 0);
    chk("per_return", 32'(st()), 32'hACE1);
    chk("per_lockup", 32'(lockup), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
